// File: rtl/sc_et_stream_decoder.sv
// Early-terminated stochastic bitstream decoder: counts 1s over a bypass-shortened
// run and rescales to 2^WIDTH. Optional half-step rounding bias under `ET_DEC_BIAS_EN.
module sc_et_stream_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bp,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_value
);
  localparam int PW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bp_q, bp_d, ctr_q, ctr_d;
  logic [PW-1:0]    pc_q, pc_d, pc_c;
  logic [WIDTH:0]   ones_q, ones_d, out_value_q, out_value_d;
  logic [WIDTH:0]   ones_nx, scaled, result;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] gen;
  logic             last;

  always_comb begin
    pc_c = '0;
    for (int i = 0; i < WIDTH; i++) pc_c = pc_c + PW'(bp[i]);
  end

  // Mirror of the generator's bypass counter: bypassed bits act as permanent
  // carry-propagate positions, so the carry out marks the final sample.
  always_comb begin
    gen  = ctr_q | bp_q;
    c    = '0;
    c[0] = 1'b1;
    for (int i = 1; i <= WIDTH; i++) c[i] = c[i-1] & gen[i-1];
    last = c[WIDTH];
  end

  assign ones_nx = ones_q + (WIDTH+1)'(bit_in);
  assign scaled  = ones_nx << pc_q;

`ifdef ET_DEC_BIAS_EN
  localparam logic [WIDTH+1:0] CAP = (WIDTH+2)'(1) << WIDTH;
  logic [WIDTH+1:0] biased;
  always_comb begin
    biased = {1'b0, scaled};
    if (pc_q != '0) biased = biased + ((WIDTH+2)'(1) << (pc_q - PW'(1)));
    result = (biased > CAP) ? CAP[WIDTH:0] : biased[WIDTH:0];
  end
`else
  assign result = scaled;
`endif

  always_comb begin
    state_d     = state_q;
    bp_d        = bp_q;
    pc_d        = pc_q;
    ctr_d       = ctr_q;
    ones_d      = ones_q;
    out_value_d = out_value_q;
    case (state_q)
      IDLE: if (start) begin
        bp_d    = bp;
        pc_d    = pc_c;
        ctr_d   = '0;
        ones_d  = '0;
        state_d = RUN;
      end
      RUN: if (bit_valid) begin
        ones_d = ones_nx;
        ctr_d  = ctr_q ^ (c[WIDTH-1:0] & ~bp_q);
        if (last) begin
          out_value_d = result;
          state_d     = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bp_q        <= '0;
      pc_q        <= '0;
      ctr_q       <= '0;
      ones_q      <= '0;
      out_value_q <= '0;
    end else begin
      state_q     <= state_d;
      bp_q        <= bp_d;
      pc_q        <= pc_d;
      ctr_q       <= ctr_d;
      ones_q      <= ones_d;
      out_value_q <= out_value_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_value = out_value_q;
endmodule
